// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: sequences operand reads, ALU handshake and write-back.
// Optional REGFILE_R0_ZERO_EN: index 0 reads as zero and writes to index 0 are dropped.
module regfile_access_ctrl #(
    parameter int WORD_LENGTH  = 8,
    parameter int ADDR_W       = 2,
    parameter int EXEC_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_src1,
    input  logic [ADDR_W-1:0]      req_src2,
    input  logic [ADDR_W-1:0]      req_dst,
    input  logic                   req_wb,
    output logic [ADDR_W-1:0]      read_reg1,
    output logic [ADDR_W-1:0]      read_reg2,
    input  logic [WORD_LENGTH-1:0] read_data1,
    input  logic [WORD_LENGTH-1:0] read_data2,
    output logic [ADDR_W-1:0]      write_reg,
    output logic [WORD_LENGTH-1:0] write_data,
    output logic                   write_reg_en,
    output logic                   op_valid,
    output logic [WORD_LENGTH-1:0] op_a,
    output logic [WORD_LENGTH-1:0] op_b,
    input  logic                   alu_done,
    input  logic [WORD_LENGTH-1:0] alu_result,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_EXEC,
        S_WRITE,
        S_SETTLE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(EXEC_TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] dst_q;
    logic              wb_q;
    logic [7:0]        exec_cnt;

    logic [WORD_LENGTH-1:0] cap_a;
    logic [WORD_LENGTH-1:0] cap_b;
    logic                   dst_writable;

    assign req_ready = (state == S_IDLE);

    // read_reg1/2 still hold the sampled sources during CAPT, so they select the zero override
    always_comb begin
        cap_a        = read_data1;
        cap_b        = read_data2;
        dst_writable = 1'b1;
`ifdef REGFILE_R0_ZERO_EN
        if (read_reg1 == '0) cap_a = '0;
        if (read_reg2 == '0) cap_b = '0;
        dst_writable = (dst_q != '0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            dst_q        <= '0;
            wb_q         <= 1'b0;
            exec_cnt     <= '0;
            read_reg1    <= '0;
            read_reg2    <= '0;
            write_reg    <= '0;
            write_data   <= '0;
            write_reg_en <= 1'b0;
            op_valid     <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        read_reg1 <= req_src1;
                        read_reg2 <= req_src2;
                        dst_q     <= req_dst;
                        wb_q      <= req_wb;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_CAPT;
                end
                S_CAPT: begin
                    op_a     <= cap_a;
                    op_b     <= cap_b;
                    op_valid <= 1'b1;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    if (alu_done) begin
                        write_data <= alu_result;
                        op_valid   <= 1'b0;
                        exec_cnt   <= '0;
                        if (wb_q) begin
                            write_reg    <= dst_q;
                            write_reg_en <= dst_writable;
                            state        <= S_WRITE;
                        end else begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else if (exec_cnt == CNT_LAST) begin
                        err      <= 1'b1;
                        op_valid <= 1'b0;
                        exec_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        exec_cnt <= exec_cnt + 8'd1;
                    end
                end
                S_WRITE: begin
                    // file loads on the following edge; index and data stay put for it
                    write_reg_en <= 1'b0;
                    state        <= S_SETTLE;
                end
                S_SETTLE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a small registered-read, delayed-write file model.
module tb_regfile_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_src1 = '0, req_src2 = '0, req_dst = '0;
    logic       req_wb = 1'b0;
    logic [1:0] read_reg1, read_reg2, write_reg;
    logic [7:0] read_data1, read_data2, write_data;
    logic       write_reg_en, op_valid, done, err;
    logic [7:0] op_a, op_b;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = '0;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_access_ctrl #(
        .WORD_LENGTH (8),
        .ADDR_W      (2),
        .EXEC_TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .req_dst     (req_dst),
        .req_wb      (req_wb),
        .read_reg1   (read_reg1),
        .read_reg2   (read_reg2),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .write_reg_en(write_reg_en),
        .op_valid    (op_valid),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .done        (done),
        .err         (err)
    );

    // register file model: 1-cycle registered read, write commits one edge after the enable
    logic [7:0] regs [4];
    logic       pend_en = 1'b0;
    logic [1:0] pend_reg = '0;
    logic [7:0] pend_data = '0;
    logic [7:0] r0_init;

    always @(posedge clk) begin
        read_data1 <= regs[read_reg1];
        read_data2 <= regs[read_reg2];
        if (rst) begin
            regs[0] <= r0_init;
            regs[1] <= 8'h12;
            regs[2] <= 8'h34;
            regs[3] <= 8'h00;
        end else if (pend_en) begin
            regs[pend_reg] <= pend_data;
        end
        pend_en   <= write_reg_en & ~rst;
        pend_reg  <= write_reg;
        pend_data <= write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // issue one request and follow it to done/err; lat counts edges after the accept edge
    task automatic run_op(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d,
                          input logic wb, input int alu_dly, input logic [7:0] res,
                          output int lat, output int wen_cnt, output logic [1:0] wreg,
                          output logic [7:0] wdata, output logic [7:0] opa,
                          output logic [7:0] opb, output logic saw_err);
        int   exec_n;
        logic got_op;
        lat = -1; wen_cnt = 0; wreg = '0; wdata = '0; opa = '0; opb = '0;
        saw_err = 1'b0; exec_n = 0; got_op = 1'b0;
        req_valid = 1'b1; req_src1 = s1; req_src2 = s2; req_dst = d; req_wb = wb;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (write_reg_en) begin
                wen_cnt++;
                wreg  = write_reg;
                wdata = write_data;
            end
            if (op_valid) begin
                if (!got_op) begin
                    opa = op_a; opb = op_b; got_op = 1'b1;
                end
                alu_done   = (exec_n == alu_dly);
                alu_result = res;
                exec_n++;
            end else begin
                alu_done = 1'b0;
            end
            if (done || err) begin
                lat     = c;
                saw_err = err;
                break;
            end
        end
        alu_done = 1'b0;
    endtask

    int         lat, wen_cnt;
    logic [1:0] wreg;
    logic [7:0] wdata, opa, opb;
    logic       serr;

    initial begin
        r0_init = R0Z ? 8'hFF : 8'h00;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_wen", write_reg_en, 0);
        check("rst_opvalid", op_valid, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_opa_opb", {op_a, op_b}, 0);
        check("rst_wdata_wreg", {write_data, write_reg}, 0);
        check("rst_rreg", {read_reg1, read_reg2}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic write-back: r3 = r1 + r2
        run_op(2'd1, 2'd2, 2'd3, 1'b1, 0, 8'h46, lat, wen_cnt, wreg, wdata, opa, opb, serr);
        check("wb_lat", lat, 5);
        check("wb_opa", opa, 8'h12);
        check("wb_opb", opb, 8'h34);
        check("wb_wen_cnt", wen_cnt, 1);
        check("wb_wreg", wreg, 3);
        check("wb_wdata", wdata, 8'h46);
        check("wb_err", serr, 0);
        check("wb_r3", regs[3], 8'h46);

        // no write-back; reads r3 just written
        run_op(2'd3, 2'd1, 2'd2, 1'b0, 0, 8'h99, lat, wen_cnt, wreg, wdata, opa, opb, serr);
        check("nowb_lat", lat, 3);
        check("nowb_wen_cnt", wen_cnt, 0);
        check("nowb_opa", opa, 8'h46);
        check("nowb_opb", opb, 8'h12);
        check("nowb_r2", regs[2], 8'h34);

        // ALU never answers
        run_op(2'd1, 2'd2, 2'd3, 1'b1, -1, 8'h00, lat, wen_cnt, wreg, wdata, opa, opb, serr);
        check("to_lat", lat, 18);
        check("to_err", serr, 1);
        check("to_done", done, 0);
        check("to_wen_cnt", wen_cnt, 0);
        check("to_ready", req_ready, 1);
        check("to_r3", regs[3], 8'h46);
        @(posedge clk); #1;
        check("to_err_pulse", err, 0);

        // alu_done on the last allowed EXEC cycle beats timeout
        run_op(2'd2, 2'd3, 2'd1, 1'b0, 15, 8'h11, lat, wen_cnt, wreg, wdata, opa, opb, serr);
        check("last_lat", lat, 18);
        check("last_err", serr, 0);

        // back-to-back: write r1, then read it on the cycle after done
        run_op(2'd2, 2'd2, 2'd1, 1'b1, 1, 8'hA5, lat, wen_cnt, wreg, wdata, opa, opb, serr);
        check("b2b1_lat", lat, 6);
        check("b2b1_wreg", wreg, 1);
        run_op(2'd1, 2'd1, 2'd0, 1'b1, 2, 8'h3C, lat, wen_cnt, wreg, wdata, opa, opb, serr);
        check("b2b2_opa", opa, 8'hA5);
        check("b2b2_opb", opb, 8'hA5);
        check("b2b2_lat", lat, 7);
        check("b2b2_wen_cnt", wen_cnt, R0Z ? 0 : 1);
        check("b2b2_r0", regs[0], R0Z ? 8'hFF : 8'h3C);

        // source index 0
        run_op(2'd0, 2'd2, 2'd0, 1'b1, 0, 8'h77, lat, wen_cnt, wreg, wdata, opa, opb, serr);
        check("r0_opa", opa, R0Z ? 8'h00 : 8'h3C);
        check("r0_opb", opb, 8'h34);
        check("r0_wen_cnt", wen_cnt, R0Z ? 0 : 1);
        check("r0_lat", lat, 5);

        // reset while in WRITE
        begin
            int   exec_n;
            logic seen_wen;
            exec_n = 0; seen_wen = 1'b0;
            req_valid = 1'b1; req_src1 = 2'd1; req_src2 = 2'd2; req_dst = 2'd3; req_wb = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (write_reg_en) begin
                    seen_wen = 1'b1;
                    break;
                end
                alu_done   = op_valid && (exec_n == 0);
                alu_result = 8'h5A;
                if (op_valid) exec_n++;
            end
            alu_done = 1'b0;
            check("rstw_reached", seen_wen, 1);
            rst = 1'b1;
            #1;
            check("rstw_wen", write_reg_en, 0);
            check("rstw_ready", req_ready, 1);
            check("rstw_outs", {write_data, write_reg, op_a, op_b, op_valid}, 0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            seen_wen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1;
                if (done || err || write_reg_en) seen_wen = 1'b1;
            end
            check("rstw_quiet", seen_wen, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
